// File: rtl/aula_hex_pkg.sv
// rtl/aula_hex_pkg.sv - register map, control layout and segment width for the hex display bank
package aula_hex_pkg;

  localparam int SEG_W = 7;

  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;

  localparam int CTRL_DECODE_EN = 0;
  localparam int CTRL_BLINK_EN  = 1;
  localparam int CTRL_BLINK_LSB = 8;
  localparam int CTRL_BLANK_LSB = 16;

  typedef struct packed {
    logic [7:0] blank_mask;
    logic [7:0] blink_mask;
    logic       blink_en;
    logic       decode_en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] word;
    word = '0;
    word[CTRL_DECODE_EN]                 = c.decode_en;
    word[CTRL_BLINK_EN]                  = c.blink_en;
    word[CTRL_BLINK_LSB +: 8]            = c.blink_mask;
    word[CTRL_BLANK_LSB +: 8]            = c.blank_mask;
    return word;
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - combinational hex nibble to active-high a..g segment pattern
module hex7seg_dec
  import aula_hex_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  // bit0 = a .. bit6 = g; 'b' and 'd' use lowercase glyphs so they differ from 8 and 0
  always_comb begin
    seg = '0;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = '0;
    endcase
  end

endmodule

// File: rtl/aula_qsys_hex_bank.sv
// rtl/aula_qsys_hex_bank.sv - Avalon-MM slave driving a bank of 7-segment digits with blank/blink control
module aula_qsys_hex_bank
  import aula_hex_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic [SEG_W*NUM_DIGITS-1:0] out_port
);

  localparam int               CW         = $clog2(BLINK_DIV);
  localparam logic [CW-1:0]    CNT_MAX    = CW'(BLINK_DIV - 1);
  localparam logic [7:0]       DIGIT_MASK = 8'((9'd1 << NUM_DIGITS) - 9'd1);
  localparam logic [SEG_W-1:0] POL        = {SEG_W{ACTIVE_LOW != 0}};

  logic                       wr_en;
  logic                       ctrl_wr;
  logic [SEG_W-1:0]           digit_q [NUM_DIGITS];
  ctrl_t                      ctrl_q;
  logic [CW-1:0]              cnt_q;
  logic                       phase_q;
  logic [SEG_W*NUM_DIGITS-1:0] out_d;

  assign wr_en   = chipselect & ~write_n;
  assign ctrl_wr = wr_en && (address == ADDR_CTRL);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) digit_q[k] <= '0;
      ctrl_q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (address == 4'(k)) digit_q[k] <= writedata[SEG_W-1:0];
      end
      if (address == ADDR_CTRL) begin
        ctrl_q.decode_en  <= writedata[CTRL_DECODE_EN];
        ctrl_q.blink_en   <= writedata[CTRL_BLINK_EN];
        ctrl_q.blink_mask <= writedata[CTRL_BLINK_LSB +: 8] & DIGIT_MASK;
        ctrl_q.blank_mask <= writedata[CTRL_BLANK_LSB +: 8] & DIGIT_MASK;
      end
    end
  end

  // A CTRL write turning blink off wins over a wrap on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (!ctrl_q.blink_en || (ctrl_wr && !writedata[CTRL_BLINK_EN])) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [SEG_W-1:0] dec_seg;
    logic [SEG_W-1:0] pat;
    logic             blank;

    hex7seg_dec u_dec (
      .hex (digit_q[i][3:0]),
      .seg (dec_seg)
    );

    assign blank = ctrl_q.blank_mask[i] | (ctrl_q.blink_en & ctrl_q.blink_mask[i] & phase_q);
    assign pat   = blank ? '0 : (ctrl_q.decode_en ? dec_seg : digit_q[i]);
    assign out_d[SEG_W*i +: SEG_W] = pat ^ POL;
  end

  always_ff @(posedge clk) begin
    if (reset) out_port <= {NUM_DIGITS{POL}};
    else       out_port <= out_d;
  end

  always_comb begin
    readdata = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (address == 4'(k)) readdata = 32'(digit_q[k]);
    end
    if (address == ADDR_CTRL)   readdata = ctrl_to_word(ctrl_q);
    if (address == ADDR_STATUS) readdata = {31'd0, phase_q};
  end

endmodule

// File: tb/tb_aula_qsys_hex_bank.sv
// tb/tb_aula_qsys_hex_bank.sv - directed self-checking bench for aula_qsys_hex_bank
module tb_aula_qsys_hex_bank;

  logic        clk;
  logic        reset;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [41:0] out_port;

  int total = 0;
  int bad   = 0;

  localparam logic [41:0] ALL_DARK = 42'h3FF_FFFF_FFFF;

  aula_qsys_hex_bank #(
    .NUM_DIGITS (6),
    .BLINK_DIV  (4),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; the write commits on the following posedge
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a);
    address = a;
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_out", out_port, ALL_DARK);
    rd(4'd0); chk("rst_rd0", readdata, 32'h0);
    rd(4'd8); chk("rst_ctrl", readdata, 32'h0);
    rd(4'd9); chk("rst_stat", readdata, 32'h0);
    @(negedge clk);

    wr(4'd0, 32'h0000_0003);
    chk("lat_old", out_port, ALL_DARK);
    @(negedge clk);
    chk("raw_d0", out_port, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7C});
    wr(4'd8, 32'h0000_0001);
    @(negedge clk);
    chk("dec_out", out_port, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30});
    rd(4'd0); chk("rd_d0", readdata, 32'h3);
    rd(4'd8); chk("rd_ctrl1", readdata, 32'h1);
    @(negedge clk);

    wr(4'd1, 32'h0000_0001);
    wr(4'd8, 32'h0000_0203);
    rd(4'd9); chk("blk_k0", readdata, 32'h0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      rd(4'd9);
      chk($sformatf("blk_stat_k%0d", k), readdata, 32'((k / 4) % 2));
      chk($sformatf("blk_d1_k%0d", k), out_port[13:7], (((k - 1) / 4) % 2) ? 7'h7F : 7'h79);
    end

    wr(4'd8, 32'h0000_0201);
    rd(4'd9); chk("wrap_clr_stat", readdata, 32'h0);
    rd(4'd8); chk("wrap_clr_ctrl", readdata, 32'h201);
    @(negedge clk);
    chk("wrap_clr_out", out_port, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h30});
    repeat (4) @(negedge clk);
    rd(4'd9); chk("hold_stat", readdata, 32'h0);

    wr(4'd6, 32'h0000_007F);
    wr(4'd12, 32'h0000_007F);
    wr(4'd9, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("ign_out", out_port, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h30});
    rd(4'd6);  chk("ign_rd6", readdata, 32'h0);
    rd(4'd12); chk("ign_rd12", readdata, 32'h0);
    rd(4'd9);  chk("ign_stat", readdata, 32'h0);
    @(negedge clk);

    wr(4'd8, 32'h00FF_FF01);
    rd(4'd8); chk("mask_trunc", readdata, 32'h003F_3F01);
    @(negedge clk);
    chk("blank_all", out_port, ALL_DARK);
    wr(4'd2, 32'hFFFF_FFA5);
    rd(4'd2); chk("rd_d2_trunc", readdata, 32'h25);
    @(negedge clk);

    wr(4'd8, 32'h0000_0203);
    repeat (6) @(negedge clk);
    rd(4'd9); chk("pre_rst_phase", readdata, 32'h1);
    reset      = 1'b1;
    address    = 4'd0;
    writedata  = 32'h0000_0005;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    chk("rst2_out", out_port, ALL_DARK);
    rd(4'd0); chk("rst2_d0", readdata, 32'h0);
    rd(4'd2); chk("rst2_d2", readdata, 32'h0);
    rd(4'd8); chk("rst2_ctrl", readdata, 32'h0);
    rd(4'd9); chk("rst2_stat", readdata, 32'h0);
    @(negedge clk);
    chk("rst2_out_hold", out_port, ALL_DARK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
